// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: data memory, forwarding outputs and W pipeline register
module memory_stage #(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        bubble_i,
    input  logic [3:0]  icode_i,
    input  logic [2:0]  stat_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        dmem_error_o,
    output logic [3:0]  icode_o,
    output logic [2:0]  stat_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o
);

    localparam logic [3:0]  I_NOP    = 4'h1;
    localparam logic [3:0]  I_RMMOVQ = 4'h4;
    localparam logic [3:0]  I_MRMOVQ = 4'h5;
    localparam logic [3:0]  I_CALL   = 4'h8;
    localparam logic [3:0]  I_RET    = 4'h9;
    localparam logic [3:0]  I_PUSHQ  = 4'hA;
    localparam logic [3:0]  I_POPQ   = 4'hB;
    localparam logic [2:0]  S_AOK    = 3'd1;
    localparam logic [2:0]  S_ADR    = 3'd3;
    localparam logic [3:0]  R_NONE   = 4'hF;
    localparam logic [63:0] MAX_ADDR = 64'(DMEM_BYTES - 8);

    logic [7:0]        mem [DMEM_BYTES];
    logic              rd;
    logic              wr;
    logic              we;
    logic [63:0]       addr;
    logic [63:0]       rdata;
    logic [ADDR_W-1:0] base;

    always_comb begin
        rd   = (icode_i == I_MRMOVQ) || (icode_i == I_RET) || (icode_i == I_POPQ);
        wr   = (icode_i == I_RMMOVQ) || (icode_i == I_CALL) || (icode_i == I_PUSHQ);
        addr = ((icode_i == I_RET) || (icode_i == I_POPQ)) ? valA_i : valE_i;
    end

    assign base = addr[ADDR_W-1:0];

    // Full 64-bit compare so huge addresses cannot alias into the array.
    assign dmem_error_o = (rd || wr) && (addr > MAX_ADDR);

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++) begin
            rdata[8*k +: 8] = mem[base + ADDR_W'(k)];
        end
    end

    assign m_valM_o = (rd && !dmem_error_o) ? rdata : '0;
    assign m_stat_o = dmem_error_o ? S_ADR : stat_i;

    // An exception already sitting in W blocks every younger store.
    assign we = wr && !dmem_error_o && (stat_i == S_AOK) && (stat_o == S_AOK)
                && !stall_i && rst_n_i;

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[base + ADDR_W'(k)] <= valA_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            icode_o <= I_NOP;
            stat_o  <= S_AOK;
            valE_o  <= '0;
            valM_o  <= '0;
            dstE_o  <= R_NONE;
            dstM_o  <= R_NONE;
        end else if (stall_i) begin
            icode_o <= icode_o;
        end else if (bubble_i) begin
            icode_o <= I_NOP;
            stat_o  <= S_AOK;
            valE_o  <= '0;
            valM_o  <= '0;
            dstE_o  <= R_NONE;
            dstM_o  <= R_NONE;
        end else begin
            icode_o <= icode_i;
            stat_o  <= m_stat_o;
            valE_o  <= valE_i;
            valM_o  <= m_valM_o;
            dstE_o  <= dstE_i;
            dstM_o  <= dstM_i;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized bench for memory_stage against a byte-array reference model
module tb_memory_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        bubble_i = 1'b0;
    logic [3:0]  icode_i = 4'h1;
    logic [2:0]  stat_i = 3'd1;
    logic [63:0] valE_i = '0;
    logic [63:0] valA_i = '0;
    logic [3:0]  dstE_i = 4'hF;
    logic [3:0]  dstM_i = 4'hF;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic        dmem_error_o;
    logic [3:0]  icode_o;
    logic [2:0]  stat_o;
    logic [63:0] valE_o;
    logic [63:0] valM_o;
    logic [3:0]  dstE_o;
    logic [3:0]  dstM_o;

    memory_stage #(.DMEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .icode_i(icode_i), .stat_i(stat_i), .valE_i(valE_i), .valA_i(valA_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .m_valM_o(m_valM_o), .m_stat_o(m_stat_o),
        .dmem_error_o(dmem_error_o), .icode_o(icode_o), .stat_o(stat_o),
        .valE_o(valE_o), .valM_o(valM_o), .dstE_o(dstE_o), .dstM_o(dstM_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: whole memory plus the W register contents.
    logic [7:0]  mem_m [1024];
    logic [3:0]  w_icode = 4'h1;
    logic [2:0]  w_stat = 3'd1;
    logic [63:0] w_valE = '0;
    logic [63:0] w_valM = '0;
    logic [3:0]  w_dstE = 4'hF;
    logic [3:0]  w_dstM = 4'hF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_addr(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
        return (ic == 4'h9 || ic == 4'hB) ? va : ve;
    endfunction

    function automatic bit ref_rd(input logic [3:0] ic);
        return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
    endfunction

    function automatic bit ref_wr(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
    endfunction

    function automatic bit ref_err(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
        return (ref_rd(ic) || ref_wr(ic)) && (ref_addr(ic, va, ve) > 64'd1016);
    endfunction

    function automatic logic [63:0] ref_valM(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
        logic [63:0] v = '0;
        int a;
        if (ref_rd(ic) && !ref_err(ic, va, ve)) begin
            a = int'(ref_addr(ic, va, ve));
            for (int k = 0; k < 8; k++) v[8*k +: 8] = mem_m[a + k];
        end
        return v;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_icode = 4'h1; w_stat = 3'd1; w_valE = '0; w_valM = '0; w_dstE = 4'hF; w_dstM = 4'hF;
        end else if (!stall_i) begin
            logic [63:0] rv;
            logic [2:0]  st;
            bit          e;
            int          a;
            e  = ref_err(icode_i, valA_i, valE_i);
            rv = ref_valM(icode_i, valA_i, valE_i);
            st = e ? 3'd3 : stat_i;
            if (ref_wr(icode_i) && !e && stat_i == 3'd1 && w_stat == 3'd1) begin
                a = int'(ref_addr(icode_i, valA_i, valE_i));
                for (int k = 0; k < 8; k++) mem_m[a + k] = valA_i[8*k +: 8];
            end
            if (bubble_i) begin
                w_icode = 4'h1; w_stat = 3'd1; w_valE = '0; w_valM = '0; w_dstE = 4'hF; w_dstM = 4'hF;
            end else begin
                w_icode = icode_i; w_stat = st; w_valE = valE_i; w_valM = rv;
                w_dstE = dstE_i; w_dstM = dstM_i;
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en && rst_n_i) begin
            bit e;
            e = ref_err(icode_i, valA_i, valE_i);
            chk("dmem_error", 64'(dmem_error_o), 64'(e));
            chk("m_stat", 64'(m_stat_o), e ? 64'd3 : 64'(stat_i));
            chk("m_valM", m_valM_o, ref_valM(icode_i, valA_i, valE_i));
            chk("w_icode", 64'(icode_o), 64'(w_icode));
            chk("w_stat", 64'(stat_o), 64'(w_stat));
            chk("w_valE", valE_o, w_valE);
            chk("w_valM", valM_o, w_valM);
            chk("w_dstE", 64'(dstE_o), 64'(w_dstE));
            chk("w_dstM", 64'(dstM_o), 64'(w_dstM));
        end
    end

    task automatic set_in(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                          input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                          input logic stl, input logic bub);
        icode_i = ic; stat_i = st; valE_i = ve; valA_i = va;
        dstE_i = de; dstM_i = dm; stall_i = stl; bubble_i = bub;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_icode"}, 64'(icode_o), 64'h1);
        chk({tag, "_stat"}, 64'(stat_o), 64'h1);
        chk({tag, "_valE"}, valE_o, 64'h0);
        chk({tag, "_valM"}, valM_o, 64'h0);
        chk({tag, "_dstE"}, 64'(dstE_o), 64'hF);
        chk({tag, "_dstM"}, 64'(dstM_o), 64'hF);
    endtask

    function automatic logic [63:0] pick_addr();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
        if (r < 4) return 64'($urandom_range(1008, 1023));
        return 64'($urandom_range(0, 1023));
    endfunction

    initial begin
        #12;
        chk_reset_vals("reset");
        rst_n_i = 1'b1;
        #4;
        chk_en = 1'b1;

        // Fill every byte so later reads are fully defined.
        for (int a = 0; a <= 1016; a += 8) begin
            set_in(4'h4, 3'd1, 64'(a), {$urandom, $urandom}, 4'hF, 4'hF, 1'b0, 1'b0);
            tick();
        end

        // Write then read back, plus popq address selection.
        set_in(4'h4, 3'd1, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        set_in(4'h5, 3'd1, 64'h10, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
        #1 chk("lit_rd_comb", m_valM_o, 64'h1122334455667788);
        tick();
        chk("lit_rd_valM", valM_o, 64'h1122334455667788);
        chk("lit_rd_dstM", 64'(dstM_o), 64'h3);
        set_in(4'h5, 3'd1, 64'h10, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        #1 chk("lit_byte10", 64'(m_valM_o[7:0]), 64'h88);
        set_in(4'hB, 3'd1, 64'h18, 64'h10, 4'h4, 4'h5, 1'b0, 1'b0);
        #1 chk("lit_popq", m_valM_o, 64'h1122334455667788);
        tick();

        // Boundary and exception containment.
        set_in(4'h4, 3'd1, 64'h20, 64'h0123456789ABCDEF, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        set_in(4'h5, 3'd1, 64'd1016, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0);
        #1 chk("lit_1016_err", 64'(dmem_error_o), 64'h0);
        tick();
        set_in(4'h5, 3'd1, 64'd1017, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0);
        #1 chk("lit_1017_err", 64'(dmem_error_o), 64'h1);
        chk("lit_1017_mstat", 64'(m_stat_o), 64'h3);
        tick();
        chk("lit_1017_stat", 64'(stat_o), 64'h3);
        chk("lit_1017_valM", valM_o, 64'h0);
        set_in(4'hA, 3'd1, 64'h20, 64'hAA, 4'h4, 4'hF, 1'b0, 1'b0);
        tick();
        set_in(4'h5, 3'd1, 64'h20, 64'h0, 4'hF, 4'h2, 1'b0, 1'b0);
        #1 chk("lit_suppress", m_valM_o, 64'h0123456789ABCDEF);
        tick();
        set_in(4'h4, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77, 4'hF, 4'hF, 1'b0, 1'b0);
        #1 chk("lit_huge_err", 64'(dmem_error_o), 64'h1);
        tick();
        set_in(4'h1, 3'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1);
        tick();

        // Stall / bubble.
        set_in(4'h4, 3'd1, 64'h30, 64'h5555AAAA5555AAAA, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        set_in(4'h5, 3'd1, 64'h10, 64'h0, 4'h2, 4'h3, 1'b0, 1'b0);
        tick();
        set_in(4'h4, 3'd1, 64'h30, 64'hDEAD, 4'h6, 4'h7, 1'b1, 1'b0);
        tick();
        set_in(4'h5, 3'd1, 64'h40, 64'h0, 4'h8, 4'h9, 1'b1, 1'b0);
        tick();
        chk("lit_stall_icode", 64'(icode_o), 64'h5);
        chk("lit_stall_valM", valM_o, 64'h1122334455667788);
        set_in(4'h4, 3'd1, 64'h50, 64'h1, 4'h6, 4'h7, 1'b1, 1'b1);
        tick();
        chk("lit_stbub_dstM", 64'(dstM_o), 64'h3);
        set_in(4'h4, 3'd1, 64'h50, 64'h1, 4'h6, 4'h7, 1'b0, 1'b1);
        tick();
        chk_reset_vals("bubble");
        set_in(4'h5, 3'd1, 64'h30, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        #1 chk("lit_stall_nowrite", m_valM_o, 64'h5555AAAA5555AAAA);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [3:0]  ic;
            logic [63:0] ve, va;
            int r = int'($urandom_range(0, 9));
            ic = (r < 7) ? 4'($urandom_range(4, 11)) : 4'($urandom);
            ve = pick_addr();
            va = (ic == 4'h9 || ic == 4'hB) ? pick_addr() : {$urandom, $urandom};
            set_in(ic, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1, ve, va,
                   4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            tick();
        end

        // Asynchronous reset between edges.
        set_in(4'h5, 3'd1, 64'h10, 64'h0, 4'h2, 4'h3, 1'b0, 1'b0);
        tick();
        #2 rst_n_i = 1'b0;
        #1 chk_reset_vals("async");
        #2 rst_n_i = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
